// File: rtl/care_request_arbiter.sv
// Care/decay command arbiter: one command in flight, decay ticks outrank care requests.
// Latency: button edge -> pending next cycle -> cmd_valid one cycle later; holds cmd until cmd_ready.
module care_request_arbiter #(
    parameter int DECAY_DIV = 50000000,
    parameter int TEST_DIV  = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_salud,
    input  logic       btn_energia,
    input  logic       btn_hambre,
    input  logic       btn_diversion,
    input  logic       btn_test,
    output logic       cmd_valid,
    output logic [1:0] cmd_stat,
    output logic       cmd_op,
    input  logic       cmd_ready,
    output logic       test_mode,
    output logic [3:0] pending,
    output logic       overrun
);
    localparam int MAX_DIV = (DECAY_DIV > TEST_DIV) ? DECAY_DIV : TEST_DIV;
    localparam int CW      = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
    localparam logic [CW-1:0] DECAY_TOP = CW'(DECAY_DIV - 1);
    localparam logic [CW-1:0] TEST_TOP  = CW'(TEST_DIV - 1);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t        r_state;
    logic [4:0]    r_btn_q;
    logic [CW-1:0] r_cnt;
    logic          r_test_mode;
    logic          r_decay_pend;
    logic          r_overrun;
    logic [3:0]    r_pending;
    logic [1:0]    r_decay_ptr;
    logic [1:0]    r_care_ptr;
    logic          r_cmd_valid;
    logic [1:0]    r_cmd_stat;
    logic          r_cmd_op;

    logic [4:0]    w_btn;
    logic [4:0]    w_rise;
    logic [CW-1:0] w_top;
    logic          w_tick;
    logic          w_hs;
    logic [3:0]    w_clr_care;
    logic          w_care_found;
    logic [1:0]    w_care_sel;
    logic [1:0]    w_idx;

    assign w_btn   = {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud};
    assign w_rise  = w_btn & ~r_btn_q;
    assign w_top   = r_test_mode ? TEST_TOP : DECAY_TOP;
    // A test-mode toggle restarts the divider, so it never coincides with a tick.
    assign w_tick  = (r_cnt == w_top) && !w_rise[4];
    assign w_hs    = (r_state == ISSUE) && cmd_ready;
    assign w_clr_care = (w_hs && r_cmd_op) ? (4'b0001 << r_cmd_stat) : 4'b0000;

    // Round-robin search begins just after the last granted care stat.
    always_comb begin
        w_care_found = 1'b0;
        w_care_sel   = r_care_ptr;
        w_idx        = r_care_ptr;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_care_ptr + 2'(i);
            if (!w_care_found && r_pending[w_idx]) begin
                w_care_found = 1'b1;
                w_care_sel   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_btn_q      <= '0;
            r_cnt        <= '0;
            r_test_mode  <= 1'b0;
            r_decay_pend <= 1'b0;
            r_overrun    <= 1'b0;
            r_pending    <= '0;
            r_decay_ptr  <= 2'd0;
            r_care_ptr   <= 2'd3;
            r_cmd_valid  <= 1'b0;
            r_cmd_stat   <= 2'd0;
            r_cmd_op     <= 1'b0;
        end else begin
            r_btn_q <= w_btn;

            if (w_rise[4]) begin
                r_test_mode <= ~r_test_mode;
                r_cnt       <= '0;
            end else if (r_cnt == w_top) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_tick && r_decay_pend)
                r_overrun <= 1'b1;
            if (w_hs && !r_cmd_op)
                r_decay_pend <= 1'b0;
            else if (w_tick)
                r_decay_pend <= 1'b1;

            // A fresh edge on the granted button outlives the handshake clear.
            r_pending <= (r_pending & ~w_clr_care) | w_rise[3:0];

            case (r_state)
                IDLE: begin
                    if (r_decay_pend) begin
                        r_state     <= ISSUE;
                        r_cmd_valid <= 1'b1;
                        r_cmd_stat  <= r_decay_ptr;
                        r_cmd_op    <= 1'b0;
                    end else if (w_care_found) begin
                        r_state     <= ISSUE;
                        r_cmd_valid <= 1'b1;
                        r_cmd_stat  <= w_care_sel;
                        r_cmd_op    <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        r_state     <= IDLE;
                        r_cmd_valid <= 1'b0;
                        if (r_cmd_op)
                            r_care_ptr <= r_cmd_stat;
                        else
                            r_decay_ptr <= r_decay_ptr + 2'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_stat  = r_cmd_stat;
    assign cmd_op    = r_cmd_op;
    assign test_mode = r_test_mode;
    assign pending   = r_pending;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_care_request_arbiter.sv
// Directed bench for care_request_arbiter with DECAY_DIV=16, TEST_DIV=4.
module tb_care_request_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_salud = 1'b0, btn_energia = 1'b0, btn_hambre = 1'b0;
    logic       btn_diversion = 1'b0, btn_test = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       cmd_valid, cmd_op, test_mode, overrun;
    logic [1:0] cmd_stat;
    logic [3:0] pending;

    int n_vec = 0;
    int n_err = 0;
    int n_cyc;

    care_request_arbiter #(.DECAY_DIV(16), .TEST_DIV(4)) dut (
        .clk(clk), .reset(reset),
        .btn_salud(btn_salud), .btn_energia(btn_energia),
        .btn_hambre(btn_hambre), .btn_diversion(btn_diversion),
        .btn_test(btn_test),
        .cmd_valid(cmd_valid), .cmd_stat(cmd_stat), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .test_mode(test_mode),
        .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!cmd_valid && n < 200);
        chk({tag, "_valid"}, cmd_valid, 1);
    endtask

    task automatic chk_cmd(input string tag, input logic [1:0] stat, input logic op);
        chk({tag, "_valid"}, cmd_valid, 1);
        chk({tag, "_stat"}, cmd_stat, stat);
        chk({tag, "_op"}, cmd_op, op);
    endtask

    initial begin
        logic [3:0] exp_p;

        // Reset state
        #2;
        chk("rst_valid", cmd_valid, 0);
        chk("rst_stat", cmd_stat, 0);
        chk("rst_op", cmd_op, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_test", test_mode, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single hambre pulse, then a re-press on the handshake cycle
        btn_hambre = 1'b1; step();
        chk("ham_pend", pending, 4'b0100);
        chk("ham_v0", cmd_valid, 0);
        btn_hambre = 1'b0; step();
        chk_cmd("ham_cmd", 2'd2, 1'b1);
        step();
        chk("ham_done_v", cmd_valid, 0);
        chk("ham_done_p", pending, 0);
        btn_hambre = 1'b1; step();
        btn_hambre = 1'b0; step();
        chk_cmd("ham2_cmd", 2'd2, 1'b1);
        btn_hambre = 1'b1; step();
        chk("setwin_p", pending, 4'b0100);
        chk("setwin_v", cmd_valid, 0);
        btn_hambre = 1'b0; step();
        chk_cmd("ham3_cmd", 2'd2, 1'b1);
        step();
        chk("ham3_done_p", pending, 0);

        // All four buttons at once: 0,1,2,3 two cycles apart
        do_reset();
        {btn_salud, btn_energia, btn_hambre, btn_diversion} = 4'b1111;
        step();
        chk("all_pend", pending, 4'b1111);
        {btn_salud, btn_energia, btn_hambre, btn_diversion} = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_cmd($sformatf("all_cmd%0d", i), 2'(i), 1'b1);
            step();
            exp_p = 4'b1111 << (i + 1);
            chk($sformatf("all_gap%0d", i), cmd_valid, 0);
            chk($sformatf("all_pend%0d", i), pending, exp_p);
        end

        // Stall with salud granted: re-presses coalesce, energia waits its turn
        do_reset();
        btn_salud = 1'b1; step();
        chk("stall_pend", pending, 4'b0001);
        btn_salud = 1'b0; cmd_ready = 1'b0; step();
        chk_cmd("stall_cmd", 2'd0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            btn_salud   = (k == 1 || k == 5);
            btn_energia = (k == 3);
            step();
            chk($sformatf("stall_hold_v%0d", k), cmd_valid, 1);
            chk($sformatf("stall_hold_s%0d", k), cmd_stat, 0);
        end
        btn_salud = 1'b0; btn_energia = 1'b0; cmd_ready = 1'b1;
        step();
        chk("stall_hs_v", cmd_valid, 0);
        chk("stall_hs_p", pending, 4'b0010);
        step();
        chk_cmd("stall_ene", 2'd1, 1'b1);
        step();
        chk("stall_end_p", pending, 0);
        step();
        chk("stall_end_v", cmd_valid, 0);
        step();
        step();
        chk_cmd("stall_decay", 2'd0, 1'b0);

        // Decay rotation every 16 cycles, then test mode every 4
        do_reset();
        wait_valid("dec0", n_cyc);
        chk("dec0_gap", n_cyc, 17);
        chk_cmd("dec0", 2'd0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            wait_valid($sformatf("dec%0d", i), n_cyc);
            chk($sformatf("dec%0d_gap", i), n_cyc, 16);
            chk_cmd($sformatf("dec%0d", i), 2'(i), 1'b0);
        end
        btn_test = 1'b1; step();
        chk("tm_on", test_mode, 1);
        chk("tm_v", cmd_valid, 0);
        btn_test = 1'b0;
        wait_valid("tdec1", n_cyc);
        chk("tdec1_gap", n_cyc, 5);
        chk_cmd("tdec1", 2'd1, 1'b0);
        for (int i = 2; i < 4; i++) begin
            wait_valid($sformatf("tdec%0d", i), n_cyc);
            chk($sformatf("tdec%0d_gap", i), n_cyc, 4);
            chk_cmd($sformatf("tdec%0d", i), 2'(i), 1'b0);
        end

        // Asynchronous reset while a command is offered
        reset = 1'b1;
        #2;
        chk("arst_valid", cmd_valid, 0);
        chk("arst_stat", cmd_stat, 0);
        chk("arst_op", cmd_op, 0);
        chk("arst_test", test_mode, 0);
        chk("arst_pend", pending, 0);
        chk("arst_ovr", overrun, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Overrun: decay stalled past the next tick
        cmd_ready = 1'b0;
        wait_valid("ovr_dec", n_cyc);
        chk("ovr_gap", n_cyc, 17);
        chk_cmd("ovr_dec", 2'd0, 1'b0);
        repeat (14) step();
        chk("ovr_pre", overrun, 0);
        step();
        chk("ovr_set", overrun, 1);
        chk_cmd("ovr_hold", 2'd0, 1'b0);
        cmd_ready = 1'b1; step();
        chk("ovr_hs_v", cmd_valid, 0);
        chk("ovr_sticky", overrun, 1);
        wait_valid("ovr_next", n_cyc);
        chk("ovr_next_gap", n_cyc, 16);
        chk_cmd("ovr_next", 2'd1, 1'b0);
        chk("ovr_sticky2", overrun, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/care_request_arbiter.md
CARE_REQUEST_ARBITER -- requirements
Module: care_request_arbiter

Interface
REQ-001 The module SHALL have parameter DECAY_DIV, default 50000000, meaning clk cycles between decay ticks in normal mode.
REQ-002 The module SHALL have parameter TEST_DIV, default 5000000, meaning clk cycles between decay ticks in test mode.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, all state on the rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have ports btn_salud, btn_energia, btn_hambre, btn_diversion, each input, 1 bit: clean, synchronous, active-high care buttons.
REQ-006 The module SHALL have port btn_test, input, 1 bit: clean, active-high test-mode toggle.
REQ-007 The module SHALL have port cmd_valid, output, 1 bit: an update command is offered to the stat datapath.
REQ-008 The module SHALL have port cmd_stat, output, 2 bits: command target, where 0=salud, 1=energia, 2=hambre, 3=diversion.
REQ-009 The module SHALL have port cmd_op, output, 1 bit: command operation, where 1=care (increment) and 0=decay (decrement).
REQ-010 The module SHALL have port cmd_ready, input, 1 bit: the datapath accepts the command.
REQ-011 The module SHALL have port test_mode, output, 1 bit: the current test-mode flag.
REQ-012 The module SHALL have port pending, output, 4 bits: care-request bits, with index equal to the stat code.
REQ-013 The module SHALL have port overrun, output, 1 bit: sticky flag indicating a decay tick was lost.

Function
REQ-014 Each button, including btn_test, SHALL be registered once; a rising edge SHALL be detected when the input is 1 and the registered copy is 0.
REQ-015 A care-button rising edge SHALL set its pending bit on that clock edge; a further edge while the bit is already set SHALL be coalesced, producing no second command.
REQ-016 A btn_test rising edge SHALL toggle test_mode and SHALL clear the decay counter to 0 on the same edge.
REQ-017 The decay counter SHALL count 0..DIV-1, with DIV = TEST_DIV when test_mode=1 and DECAY_DIV otherwise; reaching DIV-1 SHALL wrap the counter to 0 and set decay_pend.
REQ-018 Decay targets SHALL rotate through 0,1,2,3,0,...; the rotation pointer SHALL advance only when a decay command completes its handshake.
REQ-019 A tick occurring while decay_pend=1 SHALL be dropped and SHALL set overrun=1, which holds until reset.
REQ-020 The FSM SHALL have two states, IDLE and ISSUE; cmd_valid SHALL be 1 exactly in ISSUE.
REQ-021 IDLE SHALL go to ISSUE on the next edge when decay_pend=1 or any pending bit is 1, and the grant SHALL be latched on that edge.
REQ-022 Grant priority SHALL place decay above care; among care requests, the search SHALL be round-robin starting at (last granted care stat + 1) mod 4, with the pointer initialised to 3 so stat 0 is checked first.
REQ-023 In ISSUE, cmd_stat and cmd_op SHALL be held stable until cmd_ready=1; new requests SHALL NOT alter the latched grant.
REQ-024 On the cmd_valid && cmd_ready edge, the FSM SHALL clear the granted bit (pending bit or decay_pend) and return to IDLE; this yields at least 2 cycles between command starts.
REQ-025 If a new edge of the granted button occurs on the handshake cycle, the set SHALL win and the bit SHALL remain 1.
REQ-026 Latency SHALL be: button high at edge N gives pending=1 after edge N and cmd_valid=1 after edge N+1, when the FSM is idle and no decay is pending.
REQ-027 cmd_stat and cmd_op SHALL hold their last values in IDLE, and the datapath SHALL ignore them while cmd_valid=0.

Reset
REQ-028 Asserting reset SHALL immediately force: state IDLE, cmd_valid=0, cmd_stat=0, cmd_op=0, pending=0, decay_pend=0, overrun=0, test_mode=0, decay counter=0, decay pointer=0, care pointer=3, and button registers=0.
REQ-029 Reset asserted mid-handshake SHALL abandon the command and no clear or pointer update SHALL occur.

Verification (DECAY_DIV=16, TEST_DIV=4, cmd_ready=1 unless stated)
REQ-030 Pulse btn_hambre for 1 cycle -> cmd_valid=1 two edges later with cmd_stat=2, cmd_op=1, for exactly 1 cycle; pending returns to 0.
REQ-031 Raise all four buttons in the same cycle -> commands issue as stat 0,1,2,3, each 2 cycles apart.
REQ-032 Hold cmd_ready=0 for 10 cycles with salud granted, pulse btn_salud twice -> cmd_stat stays 0, then exactly one salud command issues.
REQ-033 Idle after reset -> decay commands with cmd_op=0 occur every 16 cycles with cmd_stat 0,1,2,3,0; pulse btn_test -> period becomes 4 cycles and test_mode=1.
REQ-034 Hold cmd_ready=0 for over 16 cycles while a decay command is pending -> overrun=1 and remains 1 after cmd_ready returns.
REQ-035 Assert reset while cmd_valid=1 -> cmd_valid=0 without a clock edge, and all outputs reach their reset values.
